// File: rtl/arb3_pkg.sv
// arb3_pkg -- shared encodings for the three-way memory arbiter.
//   owner_t        : 2-bit owner / datapath-select code (a=00, b=01, c=10)
//   CHOOSE_A/B/C   : select codes driven on the 3:1 datapath mux
//   OWN_A/B/C      : owner codes (same values as the select codes)
//   IDLE/BUSY      : FSM state encodings
//   owner_onehot() : owner code -> one-hot {c,b,a} grant vector
package arb3_pkg;

    typedef logic [1:0] owner_t;

    localparam owner_t CHOOSE_A = 2'b00;
    localparam owner_t CHOOSE_B = 2'b01;
    localparam owner_t CHOOSE_C = 2'b10;

    // The owner code doubles as the mux select, so a finished owner can be
    // recorded straight from the registered select.
    localparam owner_t OWN_A = CHOOSE_A;
    localparam owner_t OWN_B = CHOOSE_B;
    localparam owner_t OWN_C = CHOOSE_C;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    function automatic logic [2:0] owner_onehot(input owner_t o);
        case (o)
            OWN_A:   return 3'b001;
            OWN_B:   return 3'b010;
            OWN_C:   return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/mem_arbiter3_if.sv
// mem_arbiter3_if -- request/grant/memory handshake bundle of mem_arbiter3.
//   req_a/b/c   : level requests from ifetch / data / debug clients
//   gnt_a/b/c   : one-hot grant, high for the whole owner transaction
//   done_a/b/c  : one-cycle completion pulse to the owner
//   choose      : 3:1 datapath select (00=a, 01=b, 10=c)
//   mem_valid   : transaction valid toward the shared memory port
//   mem_ready   : memory completion strobe
//   busy        : arbiter holds an owner
//   timeout_err : one-cycle pulse on forced release (timeout build only)
// Modports: slave = arbiter side, master = clients/memory side.
interface mem_arbiter3_if;

    logic       req_a, req_b, req_c;
    logic       gnt_a, gnt_b, gnt_c;
    logic       done_a, done_b, done_c;
    logic [1:0] choose;
    logic       mem_valid;
    logic       mem_ready;
    logic       busy;
    logic       timeout_err;

    modport slave (
        input  req_a, req_b, req_c, mem_ready,
        output gnt_a, gnt_b, gnt_c, done_a, done_b, done_c,
               choose, mem_valid, busy, timeout_err
    );

    modport master (
        output req_a, req_b, req_c, mem_ready,
        input  gnt_a, gnt_b, gnt_c, done_a, done_b, done_c,
               choose, mem_valid, busy, timeout_err
    );

endinterface

// File: rtl/mem_arbiter3_rr_pick3.sv
// rr_pick3 -- combinational three-way round-robin pick.
//   req        in  3  requests {c,b,a}
//   last_owner in  2  owner served most recently
//   valid      out 1  at least one request present
//   winner     out 2  owner code of the first requester after last_owner
//                     in the order a->b->c->a
module rr_pick3
    import arb3_pkg::*;
(
    input  logic [2:0] req,
    input  owner_t     last_owner,
    output logic       valid,
    output owner_t     winner
);

    always_comb begin
        valid  = |req;
        winner = OWN_A;
        case (last_owner)
            OWN_A: begin
                if      (req[1]) winner = OWN_B;
                else if (req[2]) winner = OWN_C;
                else if (req[0]) winner = OWN_A;
            end
            OWN_B: begin
                if      (req[2]) winner = OWN_C;
                else if (req[0]) winner = OWN_A;
                else if (req[1]) winner = OWN_B;
            end
            default: begin
                if      (req[0]) winner = OWN_A;
                else if (req[1]) winner = OWN_B;
                else if (req[2]) winner = OWN_C;
            end
        endcase
    end

endmodule

// File: rtl/mem_arbiter3.sv
// mem_arbiter3 -- round-robin arbiter giving three clients (a=ifetch,
// b=data, c=debug) exclusive use of one shared memory port.
//   clk  in  sole clock, rising edge
//   rst  in  synchronous active-high reset
//   bus  mem_arbiter3_if.slave : requests, grants, done pulses, mux select,
//        mem_valid/mem_ready handshake, busy, timeout_err
// Parameters: TIMEOUT_CYCLES (max BUSY cycles before forced release) and
// TO_WIDTH (counter width, 2**TO_WIDTH > TIMEOUT_CYCLES).
// Optional feature: define MEM_ARBITER3_TIMEOUT_EN to enable the BUSY
// watchdog; without it BUSY waits for mem_ready indefinitely and
// timeout_err is tied low.
module mem_arbiter3
    import arb3_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_WIDTH       = 8
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter3_if.slave  bus
);

    if (TIMEOUT_CYCLES >= (2 ** TO_WIDTH)) begin : g_cfg_check
        $error("mem_arbiter3: TO_WIDTH too narrow for TIMEOUT_CYCLES");
    end

    logic [0:0] state_q, state_d;
    logic [2:0] gnt_q, gnt_d;          // {c,b,a}
    logic [2:0] done_q, done_d;        // {c,b,a}
    owner_t     choose_q, choose_d;    // also the current owner while BUSY
    owner_t     last_q, last_d;
    logic       mem_valid_q, mem_valid_d;

    logic       pick_valid;
    owner_t     pick_winner;

`ifdef MEM_ARBITER3_TIMEOUT_EN
    localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);
    // cnt_q = BUSY cycles already spent by the current owner
    logic [TO_WIDTH-1:0] cnt_q, cnt_d;
    logic                to_err_q, to_err_d;
`endif

    rr_pick3 u_pick (
        .req        ({bus.req_c, bus.req_b, bus.req_a}),
        .last_owner (last_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        done_d      = 3'b000;
        choose_d    = choose_q;
        last_d      = last_q;
        mem_valid_d = mem_valid_q;
`ifdef MEM_ARBITER3_TIMEOUT_EN
        cnt_d       = cnt_q;
        to_err_d    = 1'b0;
`endif
        case (state_q)
            // The done pulse coincides with the first IDLE cycle; that cycle
            // already arbitrates with the updated last_owner, so grants are
            // always separated by exactly one grant-free cycle.
            IDLE: begin
                if (pick_valid) begin
                    state_d     = BUSY;
                    gnt_d       = owner_onehot(pick_winner);
                    choose_d    = pick_winner;
                    mem_valid_d = 1'b1;
`ifdef MEM_ARBITER3_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            BUSY: begin
                // mem_ready is checked first so completion beats a timeout
                // landing in the same cycle.
                if (bus.mem_ready) begin
                    state_d     = IDLE;
                    gnt_d       = 3'b000;
                    mem_valid_d = 1'b0;
                    done_d      = gnt_q;
                    last_d      = choose_q;
                end
`ifdef MEM_ARBITER3_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d     = IDLE;
                    gnt_d       = 3'b000;
                    mem_valid_d = 1'b0;
                    last_d      = choose_q;
                    to_err_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= 3'b000;
            done_q      <= 3'b000;
            choose_q    <= CHOOSE_A;
            last_q      <= OWN_C;      // first pick after reset favours a
            mem_valid_q <= 1'b0;
`ifdef MEM_ARBITER3_TIMEOUT_EN
            cnt_q       <= '0;
            to_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            choose_q    <= choose_d;
            last_q      <= last_d;
            mem_valid_q <= mem_valid_d;
`ifdef MEM_ARBITER3_TIMEOUT_EN
            cnt_q       <= cnt_d;
            to_err_q    <= to_err_d;
`endif
        end
    end

    assign bus.gnt_a     = gnt_q[0];
    assign bus.gnt_b     = gnt_q[1];
    assign bus.gnt_c     = gnt_q[2];
    assign bus.done_a    = done_q[0];
    assign bus.done_b    = done_q[1];
    assign bus.done_c    = done_q[2];
    assign bus.choose    = choose_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.busy      = (state_q == BUSY);
`ifdef MEM_ARBITER3_TIMEOUT_EN
    assign bus.timeout_err = to_err_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter3.sv
// tb_mem_arbiter3 -- self-checking bench for mem_arbiter3. A behavioural
// model (integer owner, modular round-robin search) tracks the expected
// output vector every cycle; scenario tasks add directed checks.
module tb_mem_arbiter3;

`ifdef MEM_ARBITER3_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_arbiter3_if bus ();

    mem_arbiter3 #(.TIMEOUT_CYCLES(TO), .TO_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // {gnt c,b,a | done c,b,a | choose | mem_valid | busy | timeout_err}
    logic [10:0] obs;
    assign obs = {bus.gnt_c, bus.gnt_b, bus.gnt_a, bus.done_c, bus.done_b,
                  bus.done_a, bus.choose, bus.mem_valid, bus.busy, bus.timeout_err};

    // ---------------- reference model ----------------
    bit m_busy = 0, m_terr = 0;
    int m_owner = 0, m_last = 2, m_choose = 0, m_done = -1, m_cnt = 0;
    logic [2:0] reqv;
    assign reqv = {bus.req_c, bus.req_b, bus.req_a};

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_terr = 0; m_owner = 0; m_last = 2;
            m_choose = 0; m_done = -1; m_cnt = 0;
        end else begin
            m_done = -1;
            m_terr = 0;
            if (!m_busy) begin
                for (int k = 1; k <= 3; k++) begin
                    if (!m_busy && reqv[(m_last + k) % 3]) begin
                        m_busy = 1; m_owner = (m_last + k) % 3;
                        m_choose = m_owner; m_cnt = 0;
                    end
                end
            end else begin
                m_cnt++;
                if (bus.mem_ready) begin
                    m_busy = 0; m_done = m_owner; m_last = m_owner;
                end else if (TO_EN && m_cnt >= TO) begin
                    m_busy = 0; m_terr = 1; m_last = m_owner;
                end
            end
        end
    end

    logic [10:0] expv;
    always_comb begin
        expv = '0;
        if (m_busy) begin
            expv[8 + m_owner] = 1'b1;
            expv[2] = 1'b1;
            expv[1] = 1'b1;
        end
        if (m_done >= 0) expv[5 + m_done] = 1'b1;
        expv[4:3] = m_choose[1:0];
        expv[0] = m_terr;
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        bus.req_a = 0; bus.req_b = 0; bus.req_c = 0; bus.mem_ready = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (obs !== 11'b0) begin
            n_fail++; $display("FAIL reset_state got=%b exp=%b", obs, 11'b0);
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL reset_idle got=%b exp=%b", obs, expv);
            end
        end
    endtask

    task automatic test_rr_order();
        int order[$];
        int exp_ord[4] = '{0, 1, 2, 0};
        bus.req_a = 1; bus.req_b = 1; bus.req_c = 1; bus.mem_ready = 1;
        for (int c = 0; c < 40 && order.size() < 4; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL rr_cycle c=%0d got=%b exp=%b", c, obs, expv);
            end
            if (bus.gnt_a | bus.gnt_b | bus.gnt_c) order.push_back(int'(bus.choose));
        end
        n_checks++;
        if (order.size() != 4) begin
            n_fail++; $display("FAIL rr_count got=%0d exp=4", order.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (order[i] != exp_ord[i]) begin
                    n_fail++; $display("FAIL rr_order i=%0d got=%0d exp=%0d", i, order[i], exp_ord[i]);
                end
            end
        end
        bus.req_a = 0; bus.req_b = 0; bus.req_c = 0;
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL rr_drain got=%b exp=%b", obs, expv);
            end
        end
        bus.mem_ready = 0;
    endtask

    task automatic test_long_b();
        int hi = 0, dn = 0;
        bit prev_g = 0, ok = 1;
        bus.req_b = 1; bus.mem_ready = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL long_b_cycle c=%0d got=%b exp=%b", c, obs, expv);
            end
            if (bus.gnt_b) begin
                hi++;
                if (bus.choose !== 2'b01) ok = 0;
            end
            if (bus.done_b) begin
                dn++;
                if (!prev_g || bus.busy) ok = 0;
                bus.req_b = 0;
            end
            prev_g = bus.gnt_b;
            bus.mem_ready = bus.gnt_b && hi == 6;
        end
        n_checks++;
        if (hi != 6) begin n_fail++; $display("FAIL long_b_gnt_len got=%0d exp=6", hi); end
        n_checks++;
        if (dn != 1) begin n_fail++; $display("FAIL long_b_done_cnt got=%0d exp=1", dn); end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL long_b_sequence got=0 exp=1"); end
    endtask

    task automatic test_overlap();
        int a_cyc = 0, gap = 0, ovl = 0;
        bit a_done = 0, c_seen = 0;
        bus.req_a = 1; bus.mem_ready = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL overlap_cycle c=%0d got=%b exp=%b", c, obs, expv);
            end
            if (bus.gnt_a && bus.gnt_c) ovl++;
            if (bus.gnt_a) begin
                a_cyc++;
                if (a_cyc == 1) bus.req_c = 1;
            end
            if (bus.done_a) begin bus.req_a = 0; a_done = 1; end
            if (a_done && !bus.gnt_a && !bus.gnt_c && !c_seen) gap++;
            if (bus.gnt_c) begin c_seen = 1; bus.req_c = 0; end
            bus.mem_ready = (bus.gnt_a && a_cyc == 3) || bus.gnt_c;
        end
        n_checks++;
        if (!c_seen) begin n_fail++; $display("FAIL overlap_c_granted got=0 exp=1"); end
        n_checks++;
        if (gap != 1) begin n_fail++; $display("FAIL overlap_gap got=%0d exp=1", gap); end
        n_checks++;
        if (ovl != 0) begin n_fail++; $display("FAIL overlap_both got=%0d exp=0", ovl); end
        bus.mem_ready = 0;
    endtask

    task automatic test_rst_busy();
        bit got = 0, dnb = 0;
        int first = -1;
        bus.req_b = 1; bus.mem_ready = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL rstb_cycle got=%b exp=%b", obs, expv);
            end
            got = bus.gnt_b;
        end
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL rstb_gnt_b got=0 exp=1"); end
        repeat (2) @(negedge clk);
        rst = 1; bus.req_a = 1; bus.mem_ready = 1;
        @(negedge clk);
        n_checks++;
        if (obs !== 11'b0) begin
            n_fail++; $display("FAIL rstb_outputs got=%b exp=%b", obs, 11'b0);
        end
        rst = 0; bus.mem_ready = 0;
        for (int c = 0; c < 10 && first < 0; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL rstb_after got=%b exp=%b", obs, expv);
            end
            if (bus.done_b) dnb = 1;
            if (bus.gnt_a || bus.gnt_b) first = bus.gnt_a ? 0 : 1;
        end
        n_checks++;
        if (first != 0) begin n_fail++; $display("FAIL rstb_first_owner got=%0d exp=0", first); end
        n_checks++;
        if (dnb) begin n_fail++; $display("FAIL rstb_done_b got=1 exp=0"); end
        bus.req_a = 0; bus.req_b = 0; bus.mem_ready = 1;
        repeat (4) @(negedge clk);
        bus.mem_ready = 0;
    endtask

    task automatic test_hold();
        int bad = 0;
        bus.req_a = 1; bus.mem_ready = 0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (obs !== expv || !bus.gnt_a || bus.timeout_err) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++; $display("FAIL hold_1000 bad_cycles got=%0d exp=0 obs=%b", bad, obs);
        end
        bus.req_a = 0; bus.mem_ready = 1;
        @(negedge clk);
        n_checks++;
        if (!bus.done_a || bus.gnt_a) begin
            n_fail++; $display("FAIL hold_release got=%b exp=%b", obs, expv);
        end
        bus.mem_ready = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        int terr = 0, hi = 0, dnc = 0, terr2 = 0;
        bit saw_b = 0;
        bus.req_a = 1; bus.req_b = 1; bus.mem_ready = 0;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL timeout_cycle c=%0d got=%b exp=%b", c, obs, expv);
            end
            if (bus.timeout_err) terr++;
            if (bus.gnt_b) saw_b = 1;
        end
        n_checks++;
        if (terr < 2) begin n_fail++; $display("FAIL timeout_pulses got=%0d exp>=2", terr); end
        n_checks++;
        if (!saw_b) begin n_fail++; $display("FAIL timeout_rearb got=0 exp=1"); end
        bus.req_a = 0; bus.req_b = 0;
        repeat (6) @(negedge clk);
        bus.req_c = 1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL timeout_edge c=%0d got=%b exp=%b", c, obs, expv);
            end
            if (bus.gnt_c) hi++;
            if (bus.done_c) begin dnc++; bus.req_c = 0; end
            if (bus.timeout_err) terr2++;
            bus.mem_ready = bus.gnt_c && hi == TO;
        end
        n_checks++;
        if (dnc != 1 || terr2 != 0) begin
            n_fail++; $display("FAIL timeout_ready_wins done=%0d terr=%0d exp=1,0", dnc, terr2);
        end
        bus.mem_ready = 0;
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n_checks++;
            if (obs !== expv) begin
                n_fail++; $display("FAIL random c=%0d got=%b exp=%b", c, obs, expv);
            end
            rst = ($urandom_range(0, 99) == 0);
            if (bus.done_a) bus.req_a = 1'($urandom_range(0, 1));
            if (bus.done_b) bus.req_b = 1'($urandom_range(0, 1));
            if (bus.done_c) bus.req_c = 1'($urandom_range(0, 1));
            if (!bus.req_a && $urandom_range(0, 9) < 3) bus.req_a = 1;
            if (!bus.req_b && $urandom_range(0, 9) < 3) bus.req_b = 1;
            if (!bus.req_c && $urandom_range(0, 9) < 3) bus.req_c = 1;
            bus.mem_ready = ($urandom_range(0, 9) < 3);
        end
        rst = 0;
    endtask

    initial begin
        bus.req_a = 0; bus.req_b = 0; bus.req_c = 0; bus.mem_ready = 0;
        test_reset();
        test_rr_order();
`ifndef MEM_ARBITER3_TIMEOUT_EN
        test_long_b();
`endif
        test_overlap();
        test_rst_busy();
`ifdef MEM_ARBITER3_TIMEOUT_EN
        test_timeout();
`else
        test_hold();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
